// File: rtl/freq_div_meas.sv
// Measures period and high time of a slow clock-like input in clk cycles.
// Define FREQ_DIV_MEAS_SYNC_EN to insert a two-flop input synchronizer.
module freq_div_meas #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        OVF
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_d, high_time_d;
    logic             valid_d, locked_d, ovf_d;
    logic             cmp_ok_q, cmp_ok_d;
    logic             s, s_prev;
    logic             rise, fall;

`ifdef FREQ_DIV_MEAS_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], sig_in};
        end
    end

    assign s = sync_q[1];
`else
    assign s = sig_in;
`endif

    assign rise = s & ~s_prev;
    assign fall = ~s & s_prev;

    // cmp_ok marks that a previous measurement exists to compare against
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_cap_d    = hi_cap_q;
        period_d    = period;
        high_time_d = high_time;
        valid_d     = 1'b0;
        locked_d    = locked;
        ovf_d       = ovf;
        cmp_ok_d    = cmp_ok_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = CNT_ONE;
                if (rise) begin
                    state_d  = MEAS;
                    cmp_ok_d = 1'b0;
                end
            end
            MEAS: begin
                if (rise) begin
                    period_d    = cnt_q;
                    high_time_d = hi_cap_q;
                    valid_d     = 1'b1;
                    locked_d    = cmp_ok_q && (cnt_q == period)
                                  && (hi_cap_q == high_time);
                    cmp_ok_d    = 1'b1;
                    cnt_d       = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = OVF;
                    ovf_d    = 1'b1;
                    locked_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (fall) begin
                        hi_cap_d = cnt_q;
                    end
                end
            end
            OVF: begin
                if (rise) begin
                    state_d  = MEAS;
                    cnt_d    = CNT_ONE;
                    ovf_d    = 1'b0;
                    cmp_ok_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ONE;
            hi_cap_q  <= '0;
            s_prev    <= 1'b0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            ovf       <= 1'b0;
            cmp_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_cap_q  <= hi_cap_d;
            s_prev    <= s;
            period    <= period_d;
            high_time <= high_time_d;
            valid     <= valid_d;
            locked    <= locked_d;
            ovf       <= ovf_d;
            cmp_ok_q  <= cmp_ok_d;
        end
    end

endmodule

// File: doc/freq_div_meas.md
FREQ_DIV_MEAS -- requirements
Module: freq_div_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the cycle counter and measurement outputs; legal range 3..16.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port sig_in  input  1  divided clock under measurement, sampled by clk.
REQ-005 SHALL have port period  output  CNT_W  clk cycles between the last two sig_in rising edges.
REQ-006 SHALL have port high_time  output  CNT_W  clk cycles sig_in was high within the measured period.
REQ-007 SHALL have port valid  output  1  one-cycle pulse when period/high_time update.
REQ-008 SHALL have port locked  output  1  two consecutive measurements are identical.
REQ-009 SHALL have port ovf  output  1  no rising edge seen within 2^CNT_W-1 cycles.

Function
REQ-010 SHALL detect edges on the sampled input s: rise = s & ~s_prev; fall = ~s & s_prev.
REQ-011 SHALL implement FSM states IDLE, MEAS, OVF; IDLE on reset.
REQ-012 IDLE: counter held at 1; on rise -> MEAS, counter = 1, no valid.
REQ-013 MEAS: counter increments every cycle without rise; on fall -> hi_cap = counter; on rise -> period = counter, high_time = hi_cap, valid = 1 for one cycle, counter = 1.
REQ-014 SHALL assert valid one cycle after the clk edge at which the rising edge is detected; period/high_time are stable from that cycle until the next valid.
REQ-015 SHALL set locked with a valid whose period and high_time both equal the previous valid's values; SHALL clear locked with the first valid that differs.
REQ-016 MEAS: when counter = 2^CNT_W-1 and no rise -> OVF, ovf = 1, locked = 0, period/high_time retained, no valid.
REQ-017 OVF: counter held; on rise -> MEAS, counter = 1, ovf = 0, no valid (restart, next rise gives first measurement).
REQ-018 Simultaneous rise and counter = 2^CNT_W-1 in MEAS: rise wins; valid with period = 2^CNT_W-1; no OVF.
REQ-019 A rise with no fall since the previous rise (cannot occur with REQ-010) is not a case requiring handling; a fall in IDLE/OVF SHALL be ignored.
REQ-020 Lock comparison SHALL not use the first valid after IDLE/OVF exit; locked needs two valids after entry.

Reset
REQ-021 reset high at a clk edge SHALL force state IDLE, counter 1, hi_cap 0, s_prev 0, synchronizer flops 0, period 0, high_time 0, valid 0, locked 0, ovf 0.
REQ-022 Reset mid-measurement SHALL discard the partial period; sig_in already high at reset release counts as a rise (start only, no valid).

Configuration
REQ-023 Macro FREQ_DIV_MEAS_SYNC_EN defined: sig_in SHALL pass through a two-flop synchronizer before s, adding 2 cycles of latency to valid; measured values unchanged.
REQ-024 Macro undefined: s SHALL be sig_in directly (s_prev is the single edge-detect register); latency per REQ-014.

Verification
REQ-025 sig_in period 7, high 4 cycles, CNT_W=8: first valid at 2nd rise with period=7, high_time=4; valid every 7 cycles; locked=1 at 2nd valid.
REQ-026 Switch sig_in from period 7/high 4 to period 5/high 2: first new valid gives 5/2 with locked=0; next valid locked=1.
REQ-027 sig_in held low after lock, CNT_W=8: ovf=1 and locked=0 exactly 255 cycles after the last rise; period stays 7; next rise clears ovf, no valid; following rise gives valid.
REQ-028 Rise exactly when counter=255: valid with period=255, ovf stays 0.
REQ-029 Reset asserted mid-period with sig_in high: all outputs 0 next cycle; no valid until second rise after release.
REQ-030 Repeat REQ-025 with FREQ_DIV_MEAS_SYNC_EN: same values, each valid delayed exactly 2 cycles.
